// File: rtl/mmio_tx_fifo.sv
// CPU-facing register window feeding a first-word-fall-through transmit FIFO.
// The CPU pushes words through TXDATA, and a valid/ready consumer drains them.
module mmio_tx_fifo #(
    parameter logic [13:0] BASE_ADDR = 14'h3FF0,
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [13:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready
);

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        ovf;
        logic        full;
        logic        empty;
    } status_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf;

    logic          sel;
    logic [1:0]    off;
    logic          empty, full, pop, push_req, push_ok, flush, clr_ovf;
    status_t       st;
    logic [31:0]   rd_val;

    // 15-bit compare so a window at the very top of the space does not wrap.
    assign sel = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                 ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 15'd3));
    assign off = addr[1:0] - BASE_ADDR[1:0];

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign m_valid  = ~empty;
    assign m_data   = mem[rd_ptr];
    assign pop      = m_valid && m_ready;
    assign push_req = write_en && sel && (off == 2'd0);
    assign push_ok  = push_req && (!full || pop);
    assign flush    = write_en && sel && (off == 2'd2) && data_in[0];
    assign clr_ovf  = write_en && sel && (off == 2'd1) && data_in[2];

    always_comb begin
        st = '{rsvd_hi: '0, count: 8'(count), rsvd_lo: '0,
               ovf: ovf, full: full, empty: empty};
        rd_val = '0;
        if (off == 2'd1)
            rd_val = st;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            hit      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            data_out <= sel ? rd_val : '0;
            hit      <= sel;

            if (clr_ovf)
                ovf <= 1'b0;
            else if (push_req && !push_ok)
                ovf <= 1'b1;

            // Flush wins over a same-cycle pop; it cannot coincide with a push.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: doc/mmio_tx_fifo.md
Name: mmio_tx_fifo

Overview:
- Memory-mapped bus responder on the CPU's RAM-side interface: write_en, 14-bit word address, 32-bit data in and out.
- The CPU pushes 32-bit words into an internal FIFO through a data register, and reads FIFO status through a status register.
- An external consumer drains the FIFO over a valid/ready stream port.
- Instantiated beside block_ram. The top level ORs this block's data_out with the RAM's read data, qualified by hit.

Parameters:
- BASE_ADDR, 14'h3FF0, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- AW, 4, log2(DEPTH); pointer width. The count is AW+1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_en  in  1  bus write strobe from the CPU.
- addr  in  14  bus word address.
- data_in  in  32  bus write data.
- data_out  out  32  registered bus read data; 0 when the access was not in the register window.
- hit  out  1  registered; 1 if the previous-cycle address was inside the window.
- m_valid  out  1  FIFO non-empty.
- m_data  out  32  FIFO head word (first-word fall-through).
- m_ready  in  1  consumer accepts the head word.

Behaviour:
- Decode:
  - sel = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+3).
  - off = addr - BASE_ADDR, taking bits [1:0].
- Register map:
  - off 0, TXDATA: write pushes data_in; read returns 0.
  - off 1, STATUS: read returns {16'b0, count[7:0] zero-extended from AW+1 bits, 5'b0, ovf, full, empty}. Writing a 1 to bit 2 clears ovf; other bits are ignored.
  - off 2, CTRL: a write with data_in[0]=1 flushes the FIFO; read returns 0.
  - off 3: reserved; reads return 0 and writes are ignored.
- Read timing: one-cycle latency, matching block_ram.
  - On each rising edge, data_out <= sel ? reg_value(off) : 32'b0, and hit <= sel.
  - reg_value is sampled from pre-edge state, so STATUS read in the same cycle as a push shows the count before the push.
  - Reads have no side effects. Reads and writes are independent of write_en except for the write actions.
- Push: write_en && sel && off==0.
  - Accepted if count < DEPTH, or if a pop occurs in the same cycle (full plus simultaneous pop: the push is accepted and count is unchanged).
  - Otherwise the word is dropped and ovf is set (sticky).
- Pop: m_valid && m_ready. Advances rd_ptr and decrements count.
- Pointers wrap modulo DEPTH. Storage is DEPTH x 32 registers.
- Status bits: empty = (count==0), full = (count==DEPTH), m_valid = ~empty, m_data = mem[rd_ptr]. m_data is undefined-but-stable (hold last) when empty.
- Flush: a CTRL write with bit0 set.
  - Next edge: wr_ptr=rd_ptr=0 and count=0.
  - Flush has priority: a pop in the same cycle is ignored.
  - ovf is unchanged by flush.
- ovf clear vs set in the same cycle: not reachable, because set requires off 0 and clear requires off 1.
- Reset (asynchronous, immediate):
  - data_out=0, hit=0, count=0, pointers=0, ovf=0.
  - Therefore m_valid=0 and STATUS reads as 32'h1 afterwards.
  - FIFO contents are not reset.
- Reset mid-operation discards all queued words. The stream port shows m_valid=0 in the same cycle as rst asserts.
- Out-of-window writes have no effect. Block RAM still sees them; the top level is responsible for keeping RAM clear of the window.

Test Plan:
- Reset, then read STATUS (addr 14'h3FF1) -> data_out=32'h00000001, hit=1 one cycle later; reading addr 14'h0010 -> data_out=0, hit=0.
- Push 32'hA, 32'hB, 32'hC with m_ready=0 -> STATUS=32'h00000300, m_valid=1, m_data=32'hA. Then m_ready=1 for 3 cycles -> m_data A, B, C in order, then m_valid=0.
- Push 17 words with m_ready=0 -> after 16 pushes full=1 and STATUS=32'h00001002. The 17th word is dropped and STATUS=32'h00001006. Write 32'h4 to STATUS -> ovf cleared, STATUS=32'h00001002.
- Full FIFO, push 32'hDEAD with m_ready=1 in the same cycle -> count stays 16, ovf=0. After draining, 32'hDEAD is the last word out.
- Wrap: repeat push/pop of 40 sequential values with random m_ready -> output order matches input exactly, no loss, and count never exceeds 16.
- Push 5 words, then CTRL write 32'h1 with m_ready=1 -> next cycle m_valid=0 and STATUS=32'h00000001. Asserting rst mid-stream clears m_valid immediately.
